store_buffer: RTL and testbench

//  In-order store queue between the 2-wide execute stage and the mem block's single dmem write port.

---
 rtl/ldst_pkg.sv | 20 ++
 rtl/st_align.sv | 26 ++
 rtl/store_buffer.sv | 106 ++++++++++
 tb/tb_store_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_pkg.sv
// Load/store types shared by the pipeline, mem and the store buffer.
package ldst_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      LDST_B  = 3'd0,
      LDST_H  = 3'd1,
      LDST_W  = 3'd2,
      LDST_BU = 3'd3,
      LDST_HU = 3'd4
   } ldst_mode_e;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      ldst_mode_e      mode;
   } sb_entry_t;

endpackage

// File: rtl/st_align.sv
// Moves right-justified store data onto its byte lanes and flags misaligned stores.
module st_align
   import ldst_pkg::*;
(
   input  ldst_mode_e      mode_i,
   input  logic [1:0]      addr_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] wd_o,
   output logic            misalign_o
);

   always_comb begin
      wd_o       = data_i;
      misalign_o = 1'b0;
      case (mode_i)
         LDST_B, LDST_BU: wd_o = XLEN'(data_i[7:0]) << {addr_i, 3'b000};
         LDST_H, LDST_HU: begin
            wd_o       = XLEN'(data_i[15:0]) << {addr_i[1], 4'b0000};
            misalign_o = addr_i[0];
         end
         LDST_W:          misalign_o = (addr_i != 2'b00);
         default: ;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: up to two enqueues per cycle, one drain per cycle onto
// the dmem write port, plus word-granular load hazard detection.
module store_buffer
   import ldst_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [1:0]            st_valid_i,
   input  logic [1:0][XLEN-1:0]  st_addr_i,
   input  logic [1:0][XLEN-1:0]  st_data_i,
   input  ldst_mode_e            st_mode_i [2],
   output logic                  st_ready_o,
   output logic [1:0]            st_misalign_o,
   input  logic [1:0]            ld_valid_i,
   input  logic [1:0][XLEN-1:0]  ld_addr_i,
   output logic [1:0]            ld_hazard_o,
   output logic                  we_o,
   output logic [XLEN-1:0]       wa_o,
   output logic [XLEN-1:0]       wd_o,
   output ldst_mode_e            wm_o,
   output logic [DEPTH_LOG:0]    count_o
);

   localparam int unsigned CW = DEPTH_LOG + 1;

   sb_entry_t              entry_q [DEPTH];
   logic [DEPTH_LOG-1:0]   head_q, head_d;
   logic [DEPTH_LOG-1:0]   tail_q, tail_d, wr1_idx;
   logic [CW-1:0]          count_q, count_d;
   logic [1:0][XLEN-1:0]   al_data;
   logic [1:0]             acc;
   logic [DEPTH-1:0]       ent_valid;
   logic                   unused_ld_lsb;

   for (genvar i = 0; i < 2; i++) begin : g_lane
      st_align u_align (
         .mode_i     (st_mode_i[i]),
         .addr_i     (st_addr_i[i][1:0]),
         .data_i     (st_data_i[i]),
         .wd_o       (al_data[i]),
         .misalign_o (st_misalign_o[i])
      );
   end

   // Ready looks at the registered occupancy only, so it never depends on st_valid.
   assign st_ready_o    = (CW'(DEPTH) - count_q) >= CW'(2);
   assign acc           = st_valid_i & ~st_misalign_o & {2{st_ready_o}};
   assign we_o          = (count_q != '0);
   assign wa_o          = entry_q[head_q].addr;
   assign wd_o          = entry_q[head_q].data;
   assign wm_o          = entry_q[head_q].mode;
   assign count_o       = count_q;
   assign unused_ld_lsb = ^{ld_addr_i[0][1:0], ld_addr_i[1][1:0]};

   always_comb begin
      head_d  = head_q + DEPTH_LOG'(we_o);
      wr1_idx = tail_q + DEPTH_LOG'(acc[0]);
      tail_d  = wr1_idx + DEPTH_LOG'(acc[1]);
      count_d = count_q + CW'(acc[0]) + CW'(acc[1]) - CW'(we_o);
   end

   // Slot j is live when its distance from head (mod DEPTH) is below count.
   always_comb begin
      logic [DEPTH_LOG-1:0] off;
      ent_valid = '0;
      off       = '0;
      for (int j = 0; j < DEPTH; j++) begin
         off          = DEPTH_LOG'(j) - head_q;
         ent_valid[j] = ({1'b0, off} < count_q);
      end
   end

   always_comb begin
      ld_hazard_o = '0;
      for (int l = 0; l < 2; l++) begin
         for (int j = 0; j < DEPTH; j++)
            if (ent_valid[j] && (entry_q[j].addr[XLEN-1:2] == ld_addr_i[l][XLEN-1:2]))
               ld_hazard_o[l] = 1'b1;
         for (int k = 0; k < 2; k++)
            if (acc[k] && (st_addr_i[k][XLEN-1:2] == ld_addr_i[l][XLEN-1:2]))
               ld_hazard_o[l] = 1'b1;
         ld_hazard_o[l] = ld_hazard_o[l] & ld_valid_i[l];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int j = 0; j < DEPTH; j++) entry_q[j] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (acc[0])
            entry_q[tail_q] <= '{addr: st_addr_i[0], data: al_data[0], mode: st_mode_i[0]};
         if (acc[1])
            entry_q[wr1_idx] <= '{addr: st_addr_i[1], data: al_data[1], mode: st_mode_i[1]};
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed sequences, an alignment
// vector table and randomized traffic against a queue-based reference model.
module tb_store_buffer;
   import ldst_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        st_valid;
   logic [1:0][31:0]  st_addr, st_data;
   ldst_mode_e        st_mode [2];
   logic              st_ready;
   logic [1:0]        st_misalign;
   logic [1:0]        ld_valid;
   logic [1:0][31:0]  ld_addr;
   logic [1:0]        ld_hazard;
   logic              we;
   logic [31:0]       wa, wd;
   ldst_mode_e        wm;
   logic [2:0]        count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      ldst_mode_e  mode;
   } ment_t;

   ment_t      mq[$];
   logic [1:0] macc;

   typedef struct {
      ldst_mode_e  m;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_wd;
      logic        exp_mis;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .DEPTH_LOG(2)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .st_valid_i    (st_valid),
      .st_addr_i     (st_addr),
      .st_data_i     (st_data),
      .st_mode_i     (st_mode),
      .st_ready_o    (st_ready),
      .st_misalign_o (st_misalign),
      .ld_valid_i    (ld_valid),
      .ld_addr_i     (ld_addr),
      .ld_hazard_o   (ld_hazard),
      .we_o          (we),
      .wa_o          (wa),
      .wd_o          (wd),
      .wm_o          (wm),
      .count_o       (count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned mode_bytes(input ldst_mode_e m);
      case (m)
         LDST_B, LDST_BU: return 1;
         LDST_H, LDST_HU: return 2;
         default:         return 4;
      endcase
   endfunction

   function automatic logic model_mis(input ldst_mode_e m, input logic [31:0] a);
      return (a % mode_bytes(m)) != 0;
   endfunction

   // Keep the low size bytes of the data, then place them at the byte offset.
   function automatic logic [31:0] model_wd(input ldst_mode_e m, input logic [31:0] a,
                                            input logic [31:0] d);
      logic [63:0] keep;
      keep = (64'd1 << (8 * mode_bytes(m))) - 64'd1;
      return 32'((64'(d) & keep) << (8 * (a % 4)));
   endfunction

   task automatic drive(input logic rst, input logic [1:0] sv,
                        input logic [31:0] a0, input logic [31:0] d0, input ldst_mode_e m0,
                        input logic [31:0] a1, input logic [31:0] d1, input ldst_mode_e m1,
                        input logic [1:0] lv, input logic [31:0] la0, input logic [31:0] la1);
      reset      = rst;
      st_valid   = sv;
      st_addr[0] = a0;  st_data[0] = d0;  st_mode[0] = m0;
      st_addr[1] = a1;  st_data[1] = d1;  st_mode[1] = m1;
      ld_valid   = lv;
      ld_addr[0] = la0; ld_addr[1] = la1;
      #1;
   endtask

   task automatic idle(input logic rst);
      drive(rst, 2'b00, 0, 0, LDST_W, 0, 0, LDST_W, 2'b00, 0, 0);
   endtask

   task automatic check_all();
      int   sz;
      logic rdy;
      logic h;
      sz  = mq.size();
      rdy = (DEPTH - sz) >= 2;
      chk("st_ready", 32'(st_ready), 32'(rdy));
      chk("count", 32'(count), 32'(sz));
      chk("we", 32'(we), 32'(sz != 0));
      for (int i = 0; i < 2; i++) begin
         chk("st_misalign", 32'(st_misalign[i]), 32'(model_mis(st_mode[i], st_addr[i])));
         macc[i] = st_valid[i] & rdy & ~model_mis(st_mode[i], st_addr[i]);
      end
      if (sz != 0) begin
         chk("wa", wa, mq[0].addr);
         chk("wd", wd, mq[0].data);
         chk("wm", 32'(wm), 32'(mq[0].mode));
      end
      for (int l = 0; l < 2; l++) begin
         h = 1'b0;
         foreach (mq[k]) if ((mq[k].addr >> 2) == (ld_addr[l] >> 2)) h = 1'b1;
         for (int i = 0; i < 2; i++)
            if (macc[i] && ((st_addr[i] >> 2) == (ld_addr[l] >> 2))) h = 1'b1;
         chk("ld_hazard", 32'(ld_hazard[l]), 32'(h & ld_valid[l]));
      end
   endtask

   task automatic tick();
      ment_t e;
      @(posedge clk);
      if (reset) mq.delete();
      else begin
         if (mq.size() != 0) void'(mq.pop_front());
         for (int i = 0; i < 2; i++)
            if (macc[i]) begin
               e.addr = st_addr[i];
               e.data = model_wd(st_mode[i], st_addr[i], st_data[i]);
               e.mode = st_mode[i];
               mq.push_back(e);
            end
      end
      #1;
   endtask

   initial begin
      tbl[0] = '{LDST_B,  32'h13, 32'h0000_00AB, 32'hAB00_0000, 1'b0};
      tbl[1] = '{LDST_H,  32'h12, 32'h0000_1234, 32'h1234_0000, 1'b0};
      tbl[2] = '{LDST_H,  32'h11, 32'h0000_1234, 32'h0,        1'b1};
      tbl[3] = '{LDST_W,  32'h16, 32'h1111_2222, 32'h0,        1'b1};
      tbl[4] = '{LDST_B,  32'h10, 32'hFFFF_F1FF, 32'h0000_00FF, 1'b0};
      tbl[5] = '{LDST_W,  32'h20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
      tbl[6] = '{LDST_HU, 32'h02, 32'hABCD_1234, 32'h1234_0000, 1'b0};
      tbl[7] = '{LDST_BU, 32'h01, 32'h0000_0077, 32'h0000_7700, 1'b0};

      // Reset held for two cycles, then quiet.
      @(posedge clk); #1;
      idle(1'b1); tick(); tick();
      chk("rst_we", 32'(we), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", 32'(st_ready), 1);
      chk("rst_wa", wa, 0);
      chk("rst_wd", wd, 0);
      chk("rst_wm", 32'(wm), 32'(LDST_B));
      idle(1'b0); check_all(); tick();
      chk("idle_we", 32'(we), 0);

      // Single word store: visible the next cycle, gone one cycle later.
      drive(1'b0, 2'b01, 32'h10, 32'hDEAD_BEEF, LDST_W, 0, 0, LDST_W, 2'b00, 0, 0);
      check_all(); tick();
      idle(1'b0);
      chk("sw_we", 32'(we), 1);
      chk("sw_wa", wa, 32'h10);
      chk("sw_wd", wd, 32'hDEAD_BEEF);
      chk("sw_wm", 32'(wm), 32'(LDST_W));
      chk("sw_count", 32'(count), 1);
      check_all(); tick();
      chk("sw_count_after", 32'(count), 0);

      // Alignment table, one store at a time on lane 0.
      for (int t = 0; t < 8; t++) begin
         drive(1'b0, 2'b01, tbl[t].a, tbl[t].d, tbl[t].m, 0, 0, LDST_W, 2'b00, 0, 0);
         chk("tbl_mis", 32'(st_misalign[0]), 32'(tbl[t].exp_mis));
         check_all(); tick();
         idle(1'b0);
         chk("tbl_we", 32'(we), 32'(!tbl[t].exp_mis));
         if (!tbl[t].exp_mis) chk("tbl_wd", wd, tbl[t].exp_wd);
         check_all(); tick();
      end

      // Two stores per cycle: back-pressure once three entries are held.
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 2'b11, 32'h100 + 32'(16 * c), 32'(c), LDST_W,
               32'h104 + 32'(16 * c), 32'(c + 100), LDST_W, 2'b00, 0, 0);
         if (c == 2) begin
            chk("full_count", 32'(count), 3);
            chk("full_ready", 32'(st_ready), 0);
         end
         check_all(); tick();
      end
      idle(1'b0);
      for (int c = 0; c < 6; c++) begin check_all(); tick(); end
      chk("drained", 32'(count), 0);

      // Load hazard against a pending store to word 0x20.
      drive(1'b0, 2'b01, 32'h20, 32'h55, LDST_W, 0, 0, LDST_W, 2'b01, 32'h23, 0);
      chk("haz_same_cycle", 32'(ld_hazard[0]), 1);
      check_all(); tick();
      drive(1'b0, 2'b00, 0, 0, LDST_W, 0, 0, LDST_W, 2'b11, 32'h23, 32'h24);
      chk("haz_head", 32'(ld_hazard[0]), 1);
      chk("haz_other_word", 32'(ld_hazard[1]), 0);
      check_all(); tick();
      chk("haz_cleared", 32'(ld_hazard[0]), 0);
      check_all(); tick();

      // Reset with three entries queued discards them.
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 2'b11, 32'h200 + 32'(8 * c), 1, LDST_W, 32'h204 + 32'(8 * c), 2, LDST_W,
               2'b00, 0, 0);
         check_all(); tick();
      end
      idle(1'b1);
      chk("pre_rst_count", 32'(count), 3);
      check_all(); tick();
      idle(1'b0);
      chk("mid_rst_we", 32'(we), 0);
      chk("mid_rst_count", 32'(count), 0);
      check_all(); tick();
      chk("mid_rst_quiet", 32'(we), 0);

      // Randomized traffic on a small address window to provoke hazards.
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 63) == 0), 2'($urandom),
               32'h40 + 32'($urandom_range(0, 15)), $urandom, ldst_mode_e'($urandom_range(0, 4)),
               32'h40 + 32'($urandom_range(0, 15)), $urandom, ldst_mode_e'($urandom_range(0, 4)),
               2'($urandom),
               32'h40 + 32'($urandom_range(0, 19)), 32'h40 + 32'($urandom_range(0, 19)));
         check_all(); tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
